// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two requesters. One transaction at a time,
// memory outputs driven from registers, completion on ack or timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iC0_Read,
  input  logic        iC0_Write,
  input  logic [31:0] iC0_Addr,
  input  logic [31:0] iC0_WData,
  output logic [31:0] oC0_RData,
  output logic        oC0_Rdy,
  input  logic        iC1_Read,
  input  logic        iC1_Write,
  input  logic [31:0] iC1_Addr,
  input  logic [31:0] iC1_WData,
  output logic [31:0] oC1_RData,
  output logic        oC1_Rdy,
  output logic        oErr,
  output logic        oMem_Read,
  output logic        oMem_Write,
  output logic [31:0] oMem_Addr,
  output logic [31:0] oMem_WData,
  input  logic [31:0] iMem_RData,
  input  logic        iMem_Ack
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          is_wr_q, is_wr_d;
  logic          last_gnt_q, last_gnt_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] c0_rdata_q, c0_rdata_d;
  logic [DW-1:0] c1_rdata_q, c1_rdata_d;
  logic          c0_rdy_q, c0_rdy_d;
  logic          c1_rdy_q, c1_rdy_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req0_c;
  logic          req1_c;
  logic          gnt_c;
  logic          timeout_c;
  logic [DW-1:0] done_data_c;

  // Tie goes to whoever did not own the previous transaction.
  assign req0_c      = iC0_Read | iC0_Write;
  assign req1_c      = iC1_Read | iC1_Write;
  assign gnt_c       = (req0_c & req1_c) ? ~last_gnt_q : req1_c;
  assign timeout_c   = (cnt_q + CW'(1)) == CW'(TIMEOUT);
  assign done_data_c = iMem_Ack ? iMem_RData : ERR_DATA;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    is_wr_d     = is_wr_q;
    last_gnt_d  = last_gnt_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    c0_rdata_d  = c0_rdata_q;
    c1_rdata_d  = c1_rdata_q;
    c0_rdy_d    = 1'b0;
    c1_rdy_d    = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req0_c | req1_c) begin
          owner_d     = gnt_c;
          is_wr_d     = gnt_c ? iC1_Write : iC0_Write;
          mem_addr_d  = gnt_c ? iC1_Addr : iC0_Addr;
          mem_wdata_d = gnt_c ? iC1_WData : iC0_WData;
          mem_rd_d    = ~is_wr_d;
          mem_wr_d    = is_wr_d;
          cnt_d       = '0;
          state_d     = ST_BUSY;
        end
      end

      // Ack takes priority over a timeout landing on the same cycle.
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (iMem_Ack | timeout_c) begin
          state_d  = ST_DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          err_d    = ~iMem_Ack;
          c0_rdy_d = ~owner_q;
          c1_rdy_d = owner_q;
          if (!is_wr_q) begin
            if (owner_q) begin
              c1_rdata_d = done_data_c;
            end else begin
              c0_rdata_d = done_data_c;
            end
          end
        end
      end

      // Requests are ignored here so a requester still holding its stale
      // request is never granted twice.
      ST_DONE: begin
        last_gnt_d = owner_q;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c0_rdata_q  <= '0;
      c1_rdata_q  <= '0;
      c0_rdy_q    <= 1'b0;
      c1_rdy_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_wr_q     <= is_wr_d;
      last_gnt_q  <= last_gnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c0_rdata_q  <= c0_rdata_d;
      c1_rdata_q  <= c1_rdata_d;
      c0_rdy_q    <= c0_rdy_d;
      c1_rdy_q    <= c1_rdy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign oC0_RData  = c0_rdata_q;
  assign oC1_RData  = c1_rdata_q;
  assign oC0_Rdy    = c0_rdy_q;
  assign oC1_Rdy    = c1_rdy_q;
  assign oErr       = err_q;
  assign oMem_Read  = mem_rd_q;
  assign oMem_Write = mem_wr_q;
  assign oMem_Addr  = mem_addr_q;
  assign oMem_WData = mem_wdata_q;

  a_rdy_onehot: assert property (@(posedge iClk) disable iff (iRst)
    !(c0_rdy_q && c1_rdy_q));
  a_err_with_rdy: assert property (@(posedge iClk) disable iff (iRst)
    err_q |-> (c0_rdy_q || c1_rdy_q));
  a_strobe_excl: assert property (@(posedge iClk) disable iff (iRst)
    !(mem_rd_q && mem_wr_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a responder acks after a programmable
// number of BUSY cycles; completions are popped and checked as Rdy pulses.
module tb_mem_port_arbiter;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam logic [31:0] EXP_ERR    = 32'hDEADBEEF;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iC0_Read, iC0_Write, iC1_Read, iC1_Write;
  logic [31:0] iC0_Addr, iC0_WData, iC1_Addr, iC1_WData;
  logic [31:0] oC0_RData, oC1_RData;
  logic        oC0_Rdy, oC1_Rdy, oErr;
  logic        oMem_Read, oMem_Write;
  logic [31:0] oMem_Addr, oMem_WData;
  logic [31:0] iMem_RData;
  logic        iMem_Ack;

  typedef struct packed {
    logic        owner;
    logic        err;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay = 1;
  bit          rdata_from_addr = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] exp_rd0 = 32'h0;
  logic [31:0] exp_rd1 = 32'h0;

  mem_port_arbiter #(.TIMEOUT(TB_TIMEOUT), .ERR_DATA(EXP_ERR)) dut (
    .iClk(iClk), .iRst(iRst),
    .iC0_Read(iC0_Read), .iC0_Write(iC0_Write), .iC0_Addr(iC0_Addr),
    .iC0_WData(iC0_WData), .oC0_RData(oC0_RData), .oC0_Rdy(oC0_Rdy),
    .iC1_Read(iC1_Read), .iC1_Write(iC1_Write), .iC1_Addr(iC1_Addr),
    .iC1_WData(iC1_WData), .oC1_RData(oC1_RData), .oC1_Rdy(oC1_Rdy),
    .oErr(oErr), .oMem_Read(oMem_Read), .oMem_Write(oMem_Write),
    .oMem_Addr(oMem_Addr), .oMem_WData(oMem_WData),
    .iMem_RData(iMem_RData), .iMem_Ack(iMem_Ack)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory responder: ack on BUSY cycle number ack_delay (0 = never ack).
  initial begin
    int busy_cnt;
    busy_cnt   = 0;
    iMem_Ack   = 1'b0;
    iMem_RData = 32'h0;
    forever begin
      @(posedge iClk); #1;
      if (oMem_Read || oMem_Write) begin
        busy_cnt++;
        if (ack_delay != 0 && busy_cnt == ack_delay) begin
          iMem_Ack   = 1'b1;
          iMem_RData = rdata_from_addr ? mem_fn(oMem_Addr) : mem_rdata;
        end else begin
          iMem_Ack   = 1'b0;
          iMem_RData = 32'hFFFF_0000 ^ 32'(busy_cnt);
        end
      end else begin
        busy_cnt = 0;
        iMem_Ack = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge iClk); #1;
  endtask

  // Observes until a Rdy pulse or the cycle budget runs out; no comparisons.
  task automatic wait_rdy(input int max_cyc, output bit got, output int cyc,
                          output int rd_cyc, output int wr_cyc, output bit stable,
                          output logic [31:0] addr_seen, output logic [31:0] wdata_seen);
    bit first;
    first = 1'b1; got = 1'b0; cyc = 0; rd_cyc = 0; wr_cyc = 0; stable = 1'b1;
    addr_seen = 32'h0; wdata_seen = 32'h0;
    while (!got && cyc < max_cyc) begin
      step();
      cyc++;
      if (oMem_Read)  rd_cyc++;
      if (oMem_Write) wr_cyc++;
      if (oMem_Read || oMem_Write) begin
        if (first) begin
          addr_seen = oMem_Addr; wdata_seen = oMem_WData; first = 1'b0;
        end else if (oMem_Addr !== addr_seen || oMem_WData !== wdata_seen) begin
          stable = 1'b0;
        end
      end
      if (oC0_Rdy || oC1_Rdy) got = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    iC0_Read = 0; iC0_Write = 0; iC0_Addr = 0; iC0_WData = 0;
    iC1_Read = 0; iC1_Write = 0; iC1_Addr = 0; iC1_WData = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    iRst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({oC0_Rdy, oC1_Rdy, oErr, oMem_Read, oMem_Write} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {oC0_Rdy, oC1_Rdy, oErr, oMem_Read, oMem_Write});
    end
    n_checks++;
    if ({oMem_Addr, oMem_WData, oC0_RData, oC1_RData} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h rd0 %h rd1 %h expected all 0",
               oMem_Addr, oMem_WData, oC0_RData, oC1_RData);
    end
    iRst = 1'b0;
    exp_rd0 = 32'h0; exp_rd1 = 32'h0;
    step();
  endtask

  task automatic test_single_read_r0();
    bit got; int cyc, rdc, wrc; bit stb; logic [31:0] a, w;
    ack_delay = 1; rdata_from_addr = 1'b0; mem_rdata = 32'h12345678;
    exp_rd0 = 32'h12345678;
    sb.push_back('{owner: 1'b0, err: 1'b0, rd0: exp_rd0, rd1: exp_rd1});
    iC0_Addr = 32'h100; iC0_Read = 1'b1;
    wait_rdy(20, got, cyc, rdc, wrc, stb, a, w);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rd0_timeout: no Rdy within 20 cycles"); end
    else begin
      n_checks++;
      if (cyc !== 2 || rdc !== 1 || wrc !== 0 || a !== 32'h100) begin
        n_fail++;
        $display("FAIL rd0_timing: cyc %0d rd %0d wr %0d addr %h expected 2 1 0 00000100",
                 cyc, rdc, wrc, a);
      end
      exp_e = sb.pop_front();
      n_checks++;
      if ({oC1_Rdy, oC0_Rdy, oErr} !== {exp_e.owner, !exp_e.owner, exp_e.err}) begin
        n_fail++;
        $display("FAIL rd0_rdy: got %b expected %b", {oC1_Rdy, oC0_Rdy, oErr},
                 {exp_e.owner, !exp_e.owner, exp_e.err});
      end
      n_checks++;
      if (oC0_RData !== exp_e.rd0 || oC1_RData !== exp_e.rd1) begin
        n_fail++;
        $display("FAIL rd0_data: got %h/%h expected %h/%h", oC0_RData, oC1_RData,
                 exp_e.rd0, exp_e.rd1);
      end
    end
    step();
    n_checks++;
    if ({oC0_Rdy, oC1_Rdy, oMem_Read, oMem_Write} !== 4'b0) begin
      n_fail++;
      $display("FAIL rd0_after_done: got %b expected 0000 (single pulse, no stale grant)",
               {oC0_Rdy, oC1_Rdy, oMem_Read, oMem_Write});
    end
    iC0_Read = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_single_write_r1();
    bit got; int cyc, rdc, wrc; bit stb; logic [31:0] a, w;
    ack_delay = 3; mem_rdata = 32'h77777777;
    sb.push_back('{owner: 1'b1, err: 1'b0, rd0: exp_rd0, rd1: exp_rd1});
    iC1_Addr = 32'h200; iC1_WData = 32'hCAFEF00D; iC1_Write = 1'b1;
    wait_rdy(20, got, cyc, rdc, wrc, stb, a, w);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL wr1_timeout: no Rdy within 20 cycles"); end
    else begin
      n_checks++;
      if (cyc !== 4 || wrc !== 3 || rdc !== 0 || !stb) begin
        n_fail++;
        $display("FAIL wr1_strobe: cyc %0d wr %0d rd %0d stable %0d expected 4 3 0 1",
                 cyc, wrc, rdc, stb);
      end
      n_checks++;
      if (a !== 32'h200 || w !== 32'hCAFEF00D) begin
        n_fail++;
        $display("FAIL wr1_bus: addr %h data %h expected 00000200 cafef00d", a, w);
      end
      exp_e = sb.pop_front();
      n_checks++;
      if ({oC1_Rdy, oC0_Rdy, oErr} !== {exp_e.owner, !exp_e.owner, exp_e.err}) begin
        n_fail++;
        $display("FAIL wr1_rdy: got %b expected %b", {oC1_Rdy, oC0_Rdy, oErr},
                 {exp_e.owner, !exp_e.owner, exp_e.err});
      end
      n_checks++;
      if (oC0_RData !== exp_e.rd0 || oC1_RData !== exp_e.rd1) begin
        n_fail++;
        $display("FAIL wr1_data: got %h/%h expected %h/%h", oC0_RData, oC1_RData,
                 exp_e.rd0, exp_e.rd1);
      end
    end
    step();
    iC1_Write = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    bit got; int cyc, rdc, wrc; bit stb; logic [31:0] a, w;
    iRst = 1'b1;
    repeat (2) step();
    iRst = 1'b0;
    exp_rd0 = 32'h0; exp_rd1 = 32'h0;
    ack_delay = 1; rdata_from_addr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_rd0 = mem_fn(32'h300);
      else            exp_rd1 = mem_fn(32'h400);
      sb.push_back('{owner: 1'(k % 2), err: 1'b0, rd0: exp_rd0, rd1: exp_rd1});
    end
    iC0_Addr = 32'h300; iC1_Addr = 32'h400; iC0_Read = 1'b1; iC1_Read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rdy(20, got, cyc, rdc, wrc, stb, a, w);
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL b2b_timeout[%0d]: no Rdy within 20 cycles", k);
        break;
      end
      n_checks++;
      if (cyc !== ((k == 0) ? 2 : 3)) begin
        n_fail++;
        $display("FAIL b2b_cadence[%0d]: got %0d cycles expected %0d", k, cyc,
                 (k == 0) ? 2 : 3);
      end
      exp_e = sb.pop_front();
      n_checks++;
      if ({oC1_Rdy, oC0_Rdy, oErr} !== {exp_e.owner, !exp_e.owner, exp_e.err}) begin
        n_fail++;
        $display("FAIL b2b_grant[%0d]: got %b expected %b", k,
                 {oC1_Rdy, oC0_Rdy, oErr}, {exp_e.owner, !exp_e.owner, exp_e.err});
      end
      n_checks++;
      if (oC0_RData !== exp_e.rd0 || oC1_RData !== exp_e.rd1) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", k, oC0_RData,
                 oC1_RData, exp_e.rd0, exp_e.rd1);
      end
    end
    iC0_Read = 1'b0; iC1_Read = 1'b0;
    sb.delete();
    repeat (2) step();
    n_checks++;
    if ({oMem_Read, oMem_Write, oC0_Rdy, oC1_Rdy} !== 4'b0) begin
      n_fail++;
      $display("FAIL b2b_quiet: got %b expected 0000",
               {oMem_Read, oMem_Write, oC0_Rdy, oC1_Rdy});
    end
    rdata_from_addr = 1'b0;
  endtask

  task automatic test_timeout();
    bit got; int cyc, rdc, wrc; bit stb; logic [31:0] a, w;
    ack_delay = 0;
    exp_rd1 = EXP_ERR;
    sb.push_back('{owner: 1'b1, err: 1'b1, rd0: exp_rd0, rd1: exp_rd1});
    iC1_Addr = 32'h240; iC1_Read = 1'b1;
    wait_rdy(20, got, cyc, rdc, wrc, stb, a, w);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL to_none: no Rdy within 20 cycles"); end
    else begin
      n_checks++;
      if (cyc !== TB_TIMEOUT + 1 || rdc !== TB_TIMEOUT) begin
        n_fail++;
        $display("FAIL to_latency: cyc %0d rd %0d expected %0d %0d", cyc, rdc,
                 TB_TIMEOUT + 1, TB_TIMEOUT);
      end
      exp_e = sb.pop_front();
      n_checks++;
      if ({oC1_Rdy, oC0_Rdy, oErr} !== {exp_e.owner, !exp_e.owner, exp_e.err}) begin
        n_fail++;
        $display("FAIL to_rdy_err: got %b expected %b", {oC1_Rdy, oC0_Rdy, oErr},
                 {exp_e.owner, !exp_e.owner, exp_e.err});
      end
      n_checks++;
      if (oC0_RData !== exp_e.rd0 || oC1_RData !== exp_e.rd1) begin
        n_fail++;
        $display("FAIL to_data: got %h/%h expected %h/%h", oC0_RData, oC1_RData,
                 exp_e.rd0, exp_e.rd1);
      end
    end
    step();
    iC1_Read = 1'b0;
    step();
    // Next transaction after a timeout completes normally.
    ack_delay = 2; mem_rdata = 32'h13579BDF;
    exp_rd0 = 32'h13579BDF;
    sb.push_back('{owner: 1'b0, err: 1'b0, rd0: exp_rd0, rd1: exp_rd1});
    iC0_Addr = 32'h180; iC0_Read = 1'b1;
    wait_rdy(20, got, cyc, rdc, wrc, stb, a, w);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL to_next_none: no Rdy within 20 cycles"); end
    else begin
      exp_e = sb.pop_front();
      n_checks++;
      if (cyc !== 3 || {oC1_Rdy, oC0_Rdy, oErr} !== {exp_e.owner, !exp_e.owner, exp_e.err}) begin
        n_fail++;
        $display("FAIL to_next_rdy: cyc %0d flags %b expected 3 %b", cyc,
                 {oC1_Rdy, oC0_Rdy, oErr}, {exp_e.owner, !exp_e.owner, exp_e.err});
      end
      n_checks++;
      if (oC0_RData !== exp_e.rd0 || oC1_RData !== exp_e.rd1) begin
        n_fail++;
        $display("FAIL to_next_data: got %h/%h expected %h/%h", oC0_RData, oC1_RData,
                 exp_e.rd0, exp_e.rd1);
      end
    end
    step();
    iC0_Read = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_coincident();
    bit got; int cyc, rdc, wrc; bit stb; logic [31:0] a, w;
    ack_delay = TB_TIMEOUT; mem_rdata = 32'h5A5A1234;
    exp_rd1 = 32'h5A5A1234;
    sb.push_back('{owner: 1'b1, err: 1'b0, rd0: exp_rd0, rd1: exp_rd1});
    iC1_Addr = 32'h280; iC1_Read = 1'b1;
    wait_rdy(20, got, cyc, rdc, wrc, stb, a, w);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL coin_none: no Rdy within 20 cycles"); end
    else begin
      exp_e = sb.pop_front();
      n_checks++;
      if (cyc !== TB_TIMEOUT + 1 ||
          {oC1_Rdy, oC0_Rdy, oErr} !== {exp_e.owner, !exp_e.owner, exp_e.err}) begin
        n_fail++;
        $display("FAIL coin_rdy_err: cyc %0d flags %b expected %0d %b", cyc,
                 {oC1_Rdy, oC0_Rdy, oErr}, TB_TIMEOUT + 1,
                 {exp_e.owner, !exp_e.owner, exp_e.err});
      end
      n_checks++;
      if (oC0_RData !== exp_e.rd0 || oC1_RData !== exp_e.rd1) begin
        n_fail++;
        $display("FAIL coin_data: got %h/%h expected %h/%h", oC0_RData, oC1_RData,
                 exp_e.rd0, exp_e.rd1);
      end
    end
    step();
    iC1_Read = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_busy();
    bit got; int cyc, rdc, wrc; bit stb; logic [31:0] a, w;
    ack_delay = 0;
    iC0_Addr = 32'h140; iC0_Read = 1'b1;
    step();
    n_checks++;
    if (oMem_Read !== 1'b1) begin
      n_fail++;
      $display("FAIL rb_accept: oMem_Read %b expected 1", oMem_Read);
    end
    step();
    iRst = 1'b1;
    step();
    n_checks++;
    if ({oMem_Read, oMem_Write, oC0_Rdy, oC1_Rdy, oErr} !== 5'b0 ||
        {oMem_Addr, oC0_RData, oC1_RData} !== 96'h0) begin
      n_fail++;
      $display("FAIL rb_cleared: flags %b addr %h rd0 %h rd1 %h expected all 0",
               {oMem_Read, oMem_Write, oC0_Rdy, oC1_Rdy, oErr}, oMem_Addr,
               oC0_RData, oC1_RData);
    end
    iRst = 1'b0;
    exp_rd0 = 32'h0; exp_rd1 = 32'h0;
    ack_delay = 1; mem_rdata = 32'h2468ACE0;
    exp_rd0 = 32'h2468ACE0;
    sb.push_back('{owner: 1'b0, err: 1'b0, rd0: exp_rd0, rd1: exp_rd1});
    step();
    n_checks++;
    if (oMem_Read !== 1'b1 || oMem_Addr !== 32'h140 || oC0_Rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_reaccept: rd %b addr %h rdy %b expected 1 00000140 0",
               oMem_Read, oMem_Addr, oC0_Rdy);
    end
    wait_rdy(20, got, cyc, rdc, wrc, stb, a, w);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rb_none: no Rdy within 20 cycles"); end
    else begin
      exp_e = sb.pop_front();
      n_checks++;
      if ({oC1_Rdy, oC0_Rdy, oErr} !== {exp_e.owner, !exp_e.owner, exp_e.err} ||
          oC0_RData !== exp_e.rd0 || oC1_RData !== exp_e.rd1) begin
        n_fail++;
        $display("FAIL rb_complete: flags %b rd %h/%h expected %b %h/%h",
                 {oC1_Rdy, oC0_Rdy, oErr}, oC0_RData, oC1_RData,
                 {exp_e.owner, !exp_e.owner, exp_e.err}, exp_e.rd0, exp_e.rd1);
      end
    end
    step();
    iC0_Read = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_rw_both_drop();
    bit got; int cyc, rdc, wrc; bit stb; logic [31:0] a, w;
    ack_delay = 2; mem_rdata = 32'h99999999;
    sb.push_back('{owner: 1'b0, err: 1'b0, rd0: exp_rd0, rd1: exp_rd1});
    iC0_Addr = 32'h500; iC0_WData = 32'h11112222; iC0_Read = 1'b1; iC0_Write = 1'b1;
    step();
    n_checks++;
    if ({oMem_Write, oMem_Read} !== 2'b10 || oMem_WData !== 32'h11112222) begin
      n_fail++;
      $display("FAIL rw_is_write: wr/rd %b data %h expected 10 11112222",
               {oMem_Write, oMem_Read}, oMem_WData);
    end
    iC0_Read = 1'b0; iC0_Write = 1'b0;
    wait_rdy(20, got, cyc, rdc, wrc, stb, a, w);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rw_drop_none: no Rdy within 20 cycles"); end
    else begin
      exp_e = sb.pop_front();
      n_checks++;
      if ({oC1_Rdy, oC0_Rdy, oErr} !== {exp_e.owner, !exp_e.owner, exp_e.err} ||
          oC0_RData !== exp_e.rd0 || oC1_RData !== exp_e.rd1) begin
        n_fail++;
        $display("FAIL rw_drop_complete: flags %b rd %h/%h expected %b %h/%h",
                 {oC1_Rdy, oC0_Rdy, oErr}, oC0_RData, oC1_RData,
                 {exp_e.owner, !exp_e.owner, exp_e.err}, exp_e.rd0, exp_e.rd1);
      end
    end
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single_read_r0();
    test_single_write_r1();
    test_back_to_back();
    test_timeout();
    test_coincident();
    test_reset_busy();
    test_rw_both_drop();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the processor's single memory port between the CPU control sequencer (requester 0) and a secondary bus master such as a debug loader or DMA engine (requester 1). It accepts one transaction at a time and drives the memory strobes, address and write data from registers. It waits for the memory acknowledge, or for a timeout, and then returns read data and a one-cycle ready pulse to the owning requester. Requester 0's ready output feeds the control unit's `iRdy`.

## Interface
- `TIMEOUT`, default 16: maximum number of BUSY cycles to wait for `iMem_Ack` before aborting; legal range 2..255.
- `ERR_DATA`, default 32'hDEADBEEF: read data returned on a timed-out transaction.

Ports:
- `iClk` in 1: clock; all state changes on the rising edge.
- `iRst` in 1: synchronous, active-high reset.
- `iC0_Read`, `iC0_Write` in 1 each: requester 0 read/write request, level.
- `iC0_Addr`, `iC0_WData` in 32 each: requester 0 address and write data.
- `oC0_RData` out 32: read data to requester 0.
- `oC0_Rdy` out 1: transaction-complete pulse to requester 0.
- `iC1_Read`, `iC1_Write`, `iC1_Addr`, `iC1_WData`, `oC1_RData`, `oC1_Rdy`: same as requester 0, for requester 1.
- `oErr` out 1: pulses together with a Rdy pulse when that transaction timed out.
- `oMem_Read`, `oMem_Write` out 1 each: memory strobes.
- `oMem_Addr`, `oMem_WData` out 32 each: memory address and write data.
- `iMem_RData` in 32: memory read data, valid when `iMem_Ack` is high.
- `iMem_Ack` in 1: memory completion, sampled only in BUSY.

## Operation
FSM states:
- **IDLE**
  - If any request is present, latch the owner, operation, address and write data, then go to BUSY.
  - Owner selection when only one requester is active: that requester wins.
  - Owner selection when both are active: grant the requester that is not `LastGnt`.
- **BUSY**
  - Hold the memory outputs constant from the latch.
  - The timeout counter increments each cycle.
  - If `iMem_Ack`=1: capture `iMem_RData` when the operation is a read, then go to DONE.
  - Otherwise, if the counter reaches `TIMEOUT`: substitute `ERR_DATA`, set the error flag, then go to DONE.
  - If ack and timeout coincide, the ack wins and no error is flagged.
- **DONE**
  - Assert the owner's Rdy, plus `oErr` if the error flag is set, for exactly this one cycle.
  - Update `LastGnt` to the owner.
  - Ignore all requests; go to IDLE.

Request and data rules:
- Requests are levels. A requester holds its request and inputs stable until it samples its Rdy, then drops or changes the request on the following cycle.
- The DONE cycle guarantees that a stale request is never re-accepted.
- If Read and Write are both high from one requester, the request is treated as a write.
- Write transactions leave `oCx_RData` unchanged.
- `oCx_RData` holds its last value until that requester's next completed read.
- The non-owner's outputs are unaffected by the owner's transaction.
- A requester dropping its request mid-BUSY does not abort the transaction; it still completes and pulses Rdy.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, `LastGnt`=1, so requester 0 wins the first tie.
  - All Rdy, strobe and `oErr` outputs 0.
  - Addr, WData and RData outputs 0; counter 0.
- Reset asserted mid-transaction:
  - Takes effect on the next edge: the FSM returns to IDLE and all outputs are cleared.
  - No Rdy is issued for the aborted transaction.
- Request acceptance:
  - A request present at edge E0 (state IDLE) puts the strobes on `oMem_*` in the cycle after E0.
  - `iMem_Ack` high at edge E1 = E0+1 gives Rdy high in the cycle after E1.
  - Minimum latency is therefore 2 cycles from acceptance to Rdy, and 4 edges from the request being seen to the next acceptance being possible (IDLE, BUSY, DONE, IDLE).
- Timeout:
  - `TIMEOUT` BUSY cycles without an ack give DONE on the following edge.
  - Rdy plus `oErr` then appear `TIMEOUT`+1 cycles after acceptance.
- Strobe duration: `oMem_Read`/`oMem_Write` are high only in BUSY, dropping on the edge that enters DONE.
- Back-to-back under contention: requester 0 and requester 1 strictly alternate; neither starves.

## Test plan
- **Single read, R0:** addr 0x100, memory acks on the 1st BUSY cycle with 0x12345678 → `oMem_Read` high for 1 cycle, `oC0_Rdy` pulses once, `oC0_RData`=0x12345678, `oErr`=0.
- **Single write, R1:** addr 0x200, data 0xCAFEF00D, ack after 3 cycles → `oMem_Write` high for 3 cycles with stable addr/data; `oC1_Rdy` pulses; `oC1_RData` unchanged.
- **Simultaneous requests after reset:** both requesters read continuously → grants R0, R1, R0, R1; each Rdy goes only to its owner.
- **Timeout:** no ack, `TIMEOUT`=4 → Rdy plus `oErr` 5 cycles after acceptance; RData=0xDEADBEEF; next request serviced normally.
- **Reset in BUSY:** `iRst` asserted on the 2nd BUSY cycle → next cycle state IDLE, strobes 0, no Rdy; the held request is then re-accepted after `iRst` drops.
- **Coincident ack and timeout:** ack on cycle `TIMEOUT` → real data returned, `oErr`=0.
